// File: rtl/fetch_sched_if.sv
// Fetch scheduler bus: selected fetch out, stall and pipeline feedback events in.
// Latency: none of its own; timing is owned by the scheduler that drives it.
// Backpressure: stall from the cache side holds the presented fetch in place.
interface fetch_sched_if #(
   parameter int NTHREADS = 4,
   parameter int TID_W    = $clog2(NTHREADS),
   parameter int PC_W     = 32
);
   logic                fetch_valid;
   logic [TID_W-1:0]    fetch_thread;
   logic [PC_W-1:0]     fetch_pc;
   logic [NTHREADS-1:0] thread_ready;
   logic                stall;
   logic                miss_valid;
   logic [TID_W-1:0]    miss_thread;
   logic [PC_W-1:0]     miss_pc;
   logic                fill_valid;
   logic [TID_W-1:0]    fill_thread;
   logic                replay_valid;
   logic [TID_W-1:0]    replay_thread;
   logic [PC_W-1:0]     replay_pc;
   logic                redirect_valid;
   logic [TID_W-1:0]    redirect_thread;
   logic [PC_W-1:0]     redirect_pc;

   // Scheduler side.
   modport master (
      output fetch_valid, fetch_thread, fetch_pc, thread_ready,
      input  stall,
      input  miss_valid, miss_thread, miss_pc,
      input  fill_valid, fill_thread,
      input  replay_valid, replay_thread, replay_pc,
      input  redirect_valid, redirect_thread, redirect_pc
   );

   // Cache / hazard / branch side.
   modport slave (
      input  fetch_valid, fetch_thread, fetch_pc, thread_ready,
      output stall,
      output miss_valid, miss_thread, miss_pc,
      output fill_valid, fill_thread,
      output replay_valid, replay_thread, replay_pc,
      output redirect_valid, redirect_thread, redirect_pc
   );
endinterface

// File: rtl/fetch_sched.sv
// Round-robin thread fetch scheduler with per-thread PCs and miss parking.
// Latency: zero-cycle selection from registered state; events visible next cycle.
// Backpressure: stall holds the selection; no PC increment, no pointer advance.
module fetch_sched #(
   parameter int              NTHREADS      = 4,
   parameter int              TID_W         = $clog2(NTHREADS),
   parameter int              PC_W          = 32,
   parameter logic [PC_W-1:0] RESET_PC      = 32'h1000,
   parameter logic [PC_W-1:0] THREAD_STRIDE = 32'h1000
) (
   input  logic          clk,
   input  logic          rst,
   fetch_sched_if.master bus
);

   typedef enum logic {
      ST_READY    = 1'b0,
      ST_WAIT_MEM = 1'b1
   } tstate_e;

   logic [PC_W-1:0]  pc_q  [NTHREADS];
   logic [PC_W-1:0]  pc_d  [NTHREADS];
   tstate_e          st_q  [NTHREADS];
   tstate_e          st_d  [NTHREADS];
   logic [TID_W-1:0] last_q;
   logic [TID_W-1:0] last_d;

   logic                sel_found;
   logic [TID_W-1:0]    sel_tid;
   logic [TID_W-1:0]    cand;
   logic [NTHREADS-1:0] ready_mask;
   logic                fetch_vld;
   logic                accept;

   // Pick the first READY thread after the last accepted one, wrapping around.
   always_comb begin
      sel_found  = 1'b0;
      sel_tid    = '0;
      cand       = '0;
      ready_mask = '0;
      for (int i = 1; i <= NTHREADS; i++) begin
         cand = last_q + TID_W'(i);
         if (!sel_found && st_q[cand] == ST_READY) begin
            sel_found = 1'b1;
            sel_tid   = cand;
         end
      end
      for (int t = 0; t < NTHREADS; t++) begin
         ready_mask[t] = (st_q[t] == ST_READY);
      end
   end

   assign fetch_vld        = sel_found && !rst;
   assign accept           = fetch_vld && !bus.stall;
   assign bus.fetch_valid  = fetch_vld;
   assign bus.fetch_thread = sel_tid;
   assign bus.fetch_pc     = pc_q[sel_tid];
   assign bus.thread_ready = ready_mask;

   // Next PC/state per thread; later assignments win, so the lowest priority
   // event is applied first and redirect last.
   always_comb begin
      pc_d   = pc_q;
      st_d   = st_q;
      last_d = last_q;
      if (accept) begin
         last_d = sel_tid;
      end
      for (int t = 0; t < NTHREADS; t++) begin
         if (accept && sel_tid == TID_W'(t)) begin
            pc_d[t] = pc_q[t] + PC_W'(4);
         end
         // A fill only wakes a parked thread; on a READY thread it is stale.
         if (bus.fill_valid && bus.fill_thread == TID_W'(t) && st_q[t] == ST_WAIT_MEM) begin
            st_d[t] = ST_READY;
         end
         if (bus.miss_valid && bus.miss_thread == TID_W'(t)) begin
            st_d[t] = ST_WAIT_MEM;
            pc_d[t] = bus.miss_pc;
         end
         // Replay rewinds the PC and cancels any miss/fill state change this cycle.
         if (bus.replay_valid && bus.replay_thread == TID_W'(t)) begin
            st_d[t] = st_q[t];
            pc_d[t] = bus.replay_pc;
         end
         // A redirect makes any outstanding miss wrong-path, so the thread wakes.
         if (bus.redirect_valid && bus.redirect_thread == TID_W'(t)) begin
            st_d[t] = ST_READY;
            pc_d[t] = bus.redirect_pc;
         end
      end
   end

   // State registers with synchronous reset overriding every event.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int t = 0; t < NTHREADS; t++) begin
            pc_q[t] <= RESET_PC + PC_W'(t) * THREAD_STRIDE;
            st_q[t] <= ST_READY;
         end
         last_q <= TID_W'(NTHREADS - 1);
      end else begin
         pc_q   <= pc_d;
         st_q   <= st_d;
         last_q <= last_d;
      end
   end

endmodule

// File: tb/tb_fetch_sched.sv
// Scoreboard bench for fetch_sched: stimulus pushes model predictions, monitor checks.
// Latency: predictions are for the outputs presented during the issuing cycle.
// Backpressure: random and directed stall cycles exercise the hold behaviour.
module tb_fetch_sched;

   localparam int N = 4;

   logic clk;
   logic rst;
   int   tests;
   int   fails;
   int   cyc;

   fetch_sched_if #(.NTHREADS(N), .PC_W(32)) bus ();

   fetch_sched #(.NTHREADS(N), .PC_W(32)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        vld;
      logic [1:0]  tid;
      logic [31:0] pc;
      logic [3:0]  rdy;
   } exp_t;

   exp_t exp_q[$];

   // Reference model: per-thread PC, ready flag, and last accepted thread.
   logic [31:0] m_pc [N];
   bit          m_rdy[N];
   int          m_last;

   task automatic model_reset();
      for (int t = 0; t < N; t++) begin
         m_pc[t]  = 32'h1000 + 32'(t) * 32'h1000;
         m_rdy[t] = 1'b1;
      end
      m_last = N - 1;
   endtask

   task automatic clear_events();
      bus.miss_valid      = 1'b0;
      bus.miss_thread     = '0;
      bus.miss_pc         = '0;
      bus.fill_valid      = 1'b0;
      bus.fill_thread     = '0;
      bus.replay_valid    = 1'b0;
      bus.replay_thread   = '0;
      bus.replay_pc       = '0;
      bus.redirect_valid  = 1'b0;
      bus.redirect_thread = '0;
      bus.redirect_pc     = '0;
   endtask

   // One cycle: predict what the DUT shows now, advance the model, clock.
   task automatic step();
      exp_t e;
      bit   found;
      int   sel;
      bit   acc;
      found = 1'b0;
      sel   = 0;
      for (int k = 1; k <= N; k++) begin
         int t;
         t = (m_last + k) % N;
         if (!found && m_rdy[t]) begin
            found = 1'b1;
            sel   = t;
         end
      end
      e.vld = found && !rst;
      e.tid = 2'(sel);
      e.pc  = m_pc[sel];
      for (int t = 0; t < N; t++) e.rdy[t] = m_rdy[t];
      exp_q.push_back(e);

      if (rst) begin
         model_reset();
      end else begin
         acc = e.vld && !bus.stall;
         for (int t = 0; t < N; t++) begin
            if (bus.redirect_valid && int'(bus.redirect_thread) == t) begin
               m_pc[t]  = bus.redirect_pc;
               m_rdy[t] = 1'b1;
            end else if (bus.replay_valid && int'(bus.replay_thread) == t) begin
               m_pc[t] = bus.replay_pc;
            end else if (bus.miss_valid && int'(bus.miss_thread) == t) begin
               m_pc[t]  = bus.miss_pc;
               m_rdy[t] = 1'b0;
            end else begin
               if (bus.fill_valid && int'(bus.fill_thread) == t) m_rdy[t] = 1'b1;
               if (acc && sel == t) m_pc[t] = m_pc[t] + 32'd4;
            end
         end
         if (acc) m_last = sel;
      end

      @(posedge clk);
      #1;
      cyc++;
      clear_events();
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s cycle %0d: got %h, expected %h", name, cyc, act, req);
      end
   endtask

   // Monitor: every cycle the DUT presents outputs, compare against the oldest prediction.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("fetch_valid", 32'(bus.fetch_valid), 32'(e.vld));
            chk("thread_ready", 32'(bus.thread_ready), 32'(e.rdy));
            if (e.vld) begin
               chk("fetch_thread", 32'(bus.fetch_thread), 32'(e.tid));
               chk("fetch_pc", bus.fetch_pc, e.pc);
            end
         end
      end
   end

   task automatic do_miss(input int t, input logic [31:0] pc);
      bus.miss_valid  = 1'b1;
      bus.miss_thread = 2'(t);
      bus.miss_pc     = pc;
   endtask

   task automatic do_fill(input int t);
      bus.fill_valid  = 1'b1;
      bus.fill_thread = 2'(t);
   endtask

   initial begin
      tests = 0;
      fails = 0;
      cyc   = 0;
      rst   = 1'b1;
      bus.stall = 1'b0;
      clear_events();
      model_reset();
      @(posedge clk);
      @(posedge clk);
      #1;

      // Reset state held: no fetch, all threads ready.
      step();
      rst = 1'b0;

      // Plain round robin, then a 3-cycle stall while T1@0x2000 is selected.
      step();
      bus.stall = 1'b1;
      repeat (3) step();
      bus.stall = 1'b0;
      repeat (5) step();

      // Miss on T1, then its fill.
      do_miss(1, 32'h2004);
      step();
      repeat (3) step();
      do_fill(1);
      step();
      repeat (4) step();

      // Replay and redirect on T2 in the same cycle: redirect wins.
      bus.replay_valid    = 1'b1;
      bus.replay_thread   = 2'd2;
      bus.replay_pc       = 32'h3000;
      bus.redirect_valid  = 1'b1;
      bus.redirect_thread = 2'd2;
      bus.redirect_pc     = 32'h3100;
      step();
      repeat (4) step();

      // Park all threads, wake T3 by fill, wake T0 by redirect, release the rest.
      for (int t = 0; t < N; t++) begin
         do_miss(t, 32'h0100_0000 + 32'(t) * 32'h40);
         step();
      end
      repeat (2) step();
      do_fill(3);
      step();
      step();
      bus.redirect_valid  = 1'b1;
      bus.redirect_thread = 2'd0;
      bus.redirect_pc     = 32'h0000_7770;
      step();
      repeat (3) step();
      do_fill(1);
      step();
      do_fill(2);
      step();
      repeat (4) step();

      // Reset mid-stream with a miss pending on T2 and events driven on the reset edge.
      do_miss(2, 32'h3abc);
      step();
      rst = 1'b1;
      do_fill(2);
      bus.stall = 1'b1;
      step();
      rst = 1'b0;
      bus.stall = 1'b0;
      repeat (6) step();

      // Randomized traffic.
      for (int i = 0; i < 600; i++) begin
         rst       = ($urandom_range(0, 149) == 0);
         bus.stall = ($urandom_range(0, 3) == 0);
         if ($urandom_range(0, 4) == 0) do_miss(int'($urandom_range(0, N - 1)), $urandom() & 32'hFFFF_FFFC);
         if ($urandom_range(0, 2) == 0) do_fill(int'($urandom_range(0, N - 1)));
         if ($urandom_range(0, 7) == 0) begin
            bus.replay_valid  = 1'b1;
            bus.replay_thread = 2'($urandom_range(0, N - 1));
            bus.replay_pc     = $urandom();
         end
         if ($urandom_range(0, 9) == 0) begin
            bus.redirect_valid  = 1'b1;
            bus.redirect_thread = 2'($urandom_range(0, N - 1));
            bus.redirect_pc     = (i % 50 == 0) ? 32'hFFFF_FFFC : $urandom();
         end
         step();
      end
      rst = 1'b0;
      bus.stall = 1'b0;

      // Let the monitor drain the last prediction.
      @(negedge clk);
      #1;
      tests++;
      if (exp_q.size() != 0) begin
         fails++;
         $display("FAIL scoreboard_drain: %0d predictions left, expected 0", exp_q.size());
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
